// File: rtl/keypad_scanner.sv
// 3x4 matrix keypad scanner: column drive, debounced press/release, valid/ready key output.
// Define KEYPAD_SCANNER_FIFO_EN for a 4-entry output FIFO; otherwise a single holding register.
module keypad_scanner #(
   parameter int unsigned SCAN_DIV = 4,
   parameter int unsigned DEBOUNCE = 3
) (
   input  logic       clk,
   input  logic       reset,
   output logic [2:0] col,
   input  logic [3:0] row,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [3:0] out_code,
   output logic       overflow
);

   typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_HELD} state_t;

   state_t     state, state_nxt;
   logic [7:0] div_q;
   logic [1:0] col_idx, col_idx_nxt;
   logic [3:0] row_q, row_q_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic [3:0] cnt_inc;
   logic [1:0] col_adv;
   logic       sample;
   logic       hit;
   logic       push;
   logic [3:0] push_code;
   logic       pop;

   function automatic logic [3:0] key_code(input logic [3:0] r, input logic [1:0] c);
      logic [3:0] code;
      code = 4'd0;
      case (r)
         4'b0001: code = 4'd1 + {2'b00, c};
         4'b0010: code = 4'd4 + {2'b00, c};
         4'b0100: code = 4'd7 + {2'b00, c};
         4'b1000: code = (c == 2'd0) ? 4'd10 : ((c == 2'd1) ? 4'd0 : 4'd11);
         default: code = 4'd0;
      endcase
      return code;
   endfunction

   assign sample    = (div_q == 8'(SCAN_DIV - 1));
   assign hit       = $onehot(row);
   assign cnt_inc   = cnt + 4'd1;
   assign col_adv   = (col_idx == 2'd2) ? 2'd0 : col_idx + 2'd1;
   assign col       = 3'b001 << col_idx;
   assign push_code = key_code(row, col_idx);
   assign pop       = out_valid && out_ready;

   // NOTE: sequential state uses non-blocking (<=) so every register sees pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_q   <= '0;
         state   <= S_SCAN;
         col_idx <= '0;
         row_q   <= '0;
         cnt     <= '0;
      end else begin
         div_q   <= sample ? 8'd0 : div_q + 8'd1;
         state   <= state_nxt;
         col_idx <= col_idx_nxt;
         row_q   <= row_q_nxt;
         cnt     <= cnt_nxt;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt   = state;
      col_idx_nxt = col_idx;
      row_q_nxt   = row_q;
      cnt_nxt     = cnt;
      push        = 1'b0;
      if (sample) begin
         case (state)
            S_SCAN: begin
               if (hit) begin
                  row_q_nxt = row;
                  if (DEBOUNCE == 1) begin
                     push      = 1'b1;
                     state_nxt = S_HELD;
                     cnt_nxt   = '0;
                  end else begin
                     state_nxt = S_DEBOUNCE;
                     cnt_nxt   = 4'd1;
                  end
               end else begin
                  col_idx_nxt = col_adv;
               end
            end
            S_DEBOUNCE: begin
               if (hit && (row == row_q)) begin
                  if (cnt_inc == 4'(DEBOUNCE)) begin
                     push      = 1'b1;
                     state_nxt = S_HELD;
                     cnt_nxt   = '0;
                  end else begin
                     cnt_nxt = cnt_inc;
                  end
               end else begin
                  state_nxt   = S_SCAN;
                  cnt_nxt     = '0;
                  col_idx_nxt = col_adv;
               end
            end
            S_HELD: begin
               // cnt now counts consecutive all-zero samples toward release.
               if (row == 4'b0000) begin
                  if (cnt_inc == 4'(DEBOUNCE)) begin
                     state_nxt   = S_SCAN;
                     cnt_nxt     = '0;
                     col_idx_nxt = col_adv;
                  end else begin
                     cnt_nxt = cnt_inc;
                  end
               end else begin
                  cnt_nxt = '0;
               end
            end
            default: begin
               state_nxt = S_SCAN;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

`ifdef KEYPAD_SCANNER_FIFO_EN
   logic [3:0] mem [4];
   logic [1:0] wr_ptr, rd_ptr;
   logic [2:0] level;
   logic       full, accept;

   assign full      = (level == 3'd4);
   assign accept    = push && (!full || pop);
   assign out_valid = (level != 3'd0);
   assign out_code  = mem[rd_ptr];

   // NOTE: the FIFO storage is reset too, so out_code reads 0 while reset is low.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 4; i++) mem[i] <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (accept) begin
            mem[wr_ptr] <= push_code;
            wr_ptr      <= wr_ptr + 2'd1;
         end
         if (pop) rd_ptr <= rd_ptr + 2'd1;
         level <= level + 3'(accept) - 3'(pop);
         if (push && full && !pop) overflow <= 1'b1;
      end
   end
`else
   logic       valid_q;
   logic [3:0] code_q;

   assign out_valid = valid_q;
   assign out_code  = code_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q  <= 1'b0;
         code_q   <= '0;
         overflow <= 1'b0;
      end else begin
         // A push lands when the register is empty or is being drained this same edge.
         if (push && (!valid_q || pop)) begin
            valid_q <= 1'b1;
            code_q  <= push_code;
         end else if (pop) begin
            valid_q <= 1'b0;
         end
         if (push && valid_q && !pop) overflow <= 1'b1;
      end
   end
`endif

endmodule
